// File: rtl/jp1_pio_arbiter.sv
// jp1_pio_arbiter: init sequencer, two-port round-robin bus arbiter and irq servicer for the JP1 PIO
//   i_clk, i_reset            : clock, synchronous active-high reset
//   i_req*/i_we*/i_addr*/i_wdata* : requester ports 0/1 (held until ack)
//   o_ack*/o_rdata*           : one-cycle completion pulse, read result
//   o_address/o_chipselect/o_write_n/o_writedata, i_readdata, i_irq : PIO register bus
//   o_evt_valid/o_evt_data    : captured edge-capture event
module jp1_pio_arbiter #(
  parameter logic [31:0] DIR_INIT      = 32'hFFFFFFFF,
  parameter logic [31:0] IRQ_MASK_INIT = 32'h00000000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req0,
  input  logic        i_req1,
  input  logic        i_we0,
  input  logic        i_we1,
  input  logic [1:0]  i_addr0,
  input  logic [1:0]  i_addr1,
  input  logic [31:0] i_wdata0,
  input  logic [31:0] i_wdata1,
  output logic        o_ack0,
  output logic        o_ack1,
  output logic [31:0] o_rdata0,
  output logic [31:0] o_rdata1,
  output logic [1:0]  o_address,
  output logic        o_chipselect,
  output logic        o_write_n,
  output logic [31:0] o_writedata,
  input  logic [31:0] i_readdata,
  input  logic        i_irq,
  output logic        o_evt_valid,
  output logic [31:0] o_evt_data
);
  typedef enum logic [3:0] {
    S_INIT_DIR, S_INIT_MASK, S_IDLE, S_WR, S_RD, S_RD_WAIT, S_DONE, S_IRQ_RD, S_IRQ_WAIT, S_IRQ_CLR
  } state_t;
  state_t r_state, w_next;
  logic r_ptr, r_port, r_we;
  logic [1:0] r_addr;
  logic [31:0] r_wdata, r_rdata0, r_rdata1, r_evt;
  logic w_grant, w_port, w_we, w_take, w_run, w_bus_wr, w_bus_rd;
  logic [1:0] w_addr;
  logic [31:0] w_wdata;
  // on a tie the port not granted last wins; otherwise whichever port is requesting
  always_comb begin
    w_grant = i_req0 | i_req1;
    w_port  = (i_req0 & i_req1) ? ~r_ptr : i_req1;
    w_we    = w_port ? i_we1 : i_we0;
    w_addr  = w_port ? i_addr1 : i_addr0;
    w_wdata = w_port ? i_wdata1 : i_wdata0;
    w_take  = (r_state == S_IDLE) & ~i_irq & w_grant;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT_DIR:  w_next = S_INIT_MASK;
      S_INIT_MASK: w_next = S_IDLE;
      S_IDLE:      w_next = i_irq ? S_IRQ_RD : w_grant ? (w_we ? S_WR : S_RD) : S_IDLE;
      S_WR:        w_next = S_DONE;
      S_RD:        w_next = S_RD_WAIT;
      S_RD_WAIT:   w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      S_IRQ_RD:    w_next = S_IRQ_WAIT;
      S_IRQ_WAIT:  w_next = S_IRQ_CLR;
      S_IRQ_CLR:   w_next = S_IDLE;
      default:     w_next = S_INIT_DIR;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_INIT_DIR;
      r_ptr    <= 1'b1;
      r_port   <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 2'd0;
      r_wdata  <= 32'd0;
      r_rdata0 <= 32'd0;
      r_rdata1 <= 32'd0;
      r_evt    <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_port  <= w_port;
        r_ptr   <= w_port;
        r_we    <= w_we;
        r_addr  <= w_addr;
        r_wdata <= w_wdata;
      end
      if (r_state == S_RD_WAIT && !r_port) r_rdata0 <= i_readdata;
      if (r_state == S_RD_WAIT && r_port) r_rdata1 <= i_readdata;
      if (r_state == S_IRQ_WAIT) r_evt <= i_readdata;
    end
  end
  // every output is forced quiet while reset is asserted, regardless of state
  always_comb begin
    w_run        = ~i_reset;
    w_bus_wr     = r_state inside {S_INIT_DIR, S_INIT_MASK, S_WR, S_IRQ_CLR};
    w_bus_rd     = r_state inside {S_RD, S_IRQ_RD};
    o_chipselect = w_run & (w_bus_wr | w_bus_rd);
    o_write_n    = ~(w_run & w_bus_wr);
    o_address    = !w_run ? 2'd0 :
                   r_state == S_INIT_DIR ? 2'd1 :
                   r_state == S_INIT_MASK ? 2'd2 :
                   (r_state == S_IRQ_RD || r_state == S_IRQ_CLR) ? 2'd3 :
                   (r_state == S_WR || r_state == S_RD) ? r_addr : 2'd0;
    o_writedata  = !w_run ? 32'd0 :
                   r_state == S_INIT_DIR ? DIR_INIT :
                   r_state == S_INIT_MASK ? IRQ_MASK_INIT :
                   r_state == S_IRQ_CLR ? r_evt :
                   r_state == S_WR ? r_wdata : 32'd0;
    o_ack0       = w_run & (r_state == S_DONE) & ~r_port;
    o_ack1       = w_run & (r_state == S_DONE) & r_port;
    o_rdata0     = w_run ? r_rdata0 : 32'd0;
    o_rdata1     = w_run ? r_rdata1 : 32'd0;
    o_evt_valid  = w_run & (r_state == S_IRQ_WAIT);
    // edge-capture data arrives during IRQ_WAIT, so it is forwarded alongside evt_valid
    o_evt_data   = !w_run ? 32'd0 : (r_state == S_IRQ_WAIT) ? i_readdata : r_evt;
  end
  logic w_unused;
  assign w_unused = r_we;
endmodule

// File: tb/tb_jp1_pio_arbiter.sv
// tb_jp1_pio_arbiter: directed self-checking bench with a small PIO model
module tb_jp1_pio_arbiter;
  logic clk, reset, req0, req1, we0, we1, ack0, ack1, cs, wn, irq, evt_valid;
  logic [1:0] addr0, addr1, address;
  logic [31:0] wdata0, wdata1, rdata0, rdata1, writedata, readdata, evt_data;
  logic [31:0] cap, edge_in, rd_value;
  int checks = 0, failures = 0;

  jp1_pio_arbiter dut (
    .i_clk(clk), .i_reset(reset), .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ack0(ack0), .o_ack1(ack1), .o_rdata0(rdata0), .o_rdata1(rdata1),
    .o_address(address), .o_chipselect(cs), .o_write_n(wn), .o_writedata(writedata),
    .i_readdata(readdata), .i_irq(irq), .o_evt_valid(evt_valid), .o_evt_data(evt_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  assign irq = |cap;
  always @(posedge clk) begin
    if (reset) cap <= 32'd0;
    else cap <= (cap | edge_in) & ~((cs && !wn && address == 2'd3) ? writedata : 32'd0);
    readdata <= (cs && wn) ? (address == 2'd3 ? cap : rd_value) : 32'hBAD0BAD0;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bus(input string tag, input logic c, input logic w, input logic [1:0] a, input logic [31:0] d);
    chk({tag, "_cs"}, {31'd0, cs}, {31'd0, c});
    chk({tag, "_wn"}, {31'd0, wn}, {31'd0, w});
    chk({tag, "_addr"}, {30'd0, address}, {30'd0, a});
    chk({tag, "_wdata"}, writedata, d);
  endtask

  initial begin
    reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0;
    wdata0 = 0; wdata1 = 0; edge_in = 0; rd_value = 0;
    step; step;
    bus("rst", 0, 1, 0, 0);
    chk("rst_ack0", {31'd0, ack0}, 0);
    chk("rst_ack1", {31'd0, ack1}, 0);
    chk("rst_evt_valid", {31'd0, evt_valid}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_evt_data", evt_data, 0);
    reset = 0; #1;
    bus("init_dir", 1, 0, 1, 32'hFFFFFFFF);
    chk("init_dir_ack0", {31'd0, ack0}, 0);
    step; bus("init_mask", 1, 0, 2, 0);
    chk("init_mask_ack1", {31'd0, ack1}, 0);
    step; bus("init_idle", 0, 1, 0, 0);
    // first tie after reset: port 0 first
    req0 = 1; we0 = 1; addr0 = 0; wdata0 = 32'h463;
    req1 = 1; we1 = 1; addr1 = 0; wdata1 = 32'h460;
    step; bus("tie1_first", 1, 0, 0, 32'h463);
    step; chk("tie1_ack0", {31'd0, ack0}, 1); chk("tie1_ack1_lo", {31'd0, ack1}, 0); req0 = 0;
    step; bus("tie1_gap", 0, 1, 0, 0);
    step; bus("tie1_second", 1, 0, 0, 32'h460);
    step; chk("tie1_ack1", {31'd0, ack1}, 1); chk("tie1_ack0_lo", {31'd0, ack0}, 0); req1 = 0;
    step;
    // lone write from port 0
    req0 = 1; wdata0 = 32'h3FF;
    step; bus("wr0", 1, 0, 0, 32'h3FF); chk("wr0_ack0_early", {31'd0, ack0}, 0);
    step; chk("wr0_ack0", {31'd0, ack0}, 1); chk("wr0_ack1", {31'd0, ack1}, 0); req0 = 0;
    step; chk("wr0_ack0_pulse", {31'd0, ack0}, 0);
    // tie after port 0 was granted last: port 1 first
    req0 = 1; wdata0 = 32'h463; req1 = 1; wdata1 = 32'h460;
    step; bus("tie2_first", 1, 0, 0, 32'h460);
    step; chk("tie2_ack1", {31'd0, ack1}, 1); chk("tie2_ack0_lo", {31'd0, ack0}, 0); req1 = 0;
    step;
    step; bus("tie2_second", 1, 0, 0, 32'h463);
    step; chk("tie2_ack0", {31'd0, ack0}, 1); req0 = 0;
    step;
    // port 1 read
    req1 = 1; we1 = 0; addr1 = 0; rd_value = 32'h0000A5A5;
    step; bus("rd1", 1, 1, 0, 0);
    step; bus("rd1_wait", 0, 1, 0, 0); chk("rd1_wait_ack1", {31'd0, ack1}, 0);
    step; chk("rd1_ack1", {31'd0, ack1}, 1); chk("rd1_rdata1", rdata1, 32'h0000A5A5);
    chk("rd1_rdata0", rdata0, 0); req1 = 0;
    step;
    // interrupt with a pending request
    edge_in = 32'h4;
    step; edge_in = 0;
    req0 = 1; we0 = 1; addr0 = 2; wdata0 = 32'h55;
    step; bus("irq_rd", 1, 1, 3, 0);
    step; chk("irq_evt_valid", {31'd0, evt_valid}, 1); chk("irq_evt_data", evt_data, 32'h4);
    chk("irq_wait_cs", {31'd0, cs}, 0);
    step; bus("irq_clr", 1, 0, 3, 32'h4); chk("irq_clr_evt_valid", {31'd0, evt_valid}, 0);
    chk("irq_clr_ack0", {31'd0, ack0}, 0);
    step; chk("irq_idle_cs", {31'd0, cs}, 0); chk("irq_evt_held", evt_data, 32'h4);
    step; bus("irq_req_wr", 1, 0, 2, 32'h55);
    step; chk("irq_req_ack0", {31'd0, ack0}, 1); req0 = 0;
    step;
    // reset during RD_WAIT of a held read
    req0 = 1; we0 = 0; addr0 = 1; rd_value = 32'h1111;
    step; bus("rr_rd", 1, 1, 1, 0);
    step; reset = 1; #1;
    bus("rr_reset", 0, 1, 0, 0); chk("rr_reset_ack0", {31'd0, ack0}, 0);
    step; chk("rr_reset_ack0b", {31'd0, ack0}, 0); chk("rr_reset_rdata0", rdata0, 0);
    chk("rr_reset_evt_data", evt_data, 0);
    rd_value = 32'h2222; reset = 0; #1;
    bus("rr_init_dir", 1, 0, 1, 32'hFFFFFFFF);
    step; bus("rr_init_mask", 1, 0, 2, 0);
    step; bus("rr_idle", 0, 1, 0, 0);
    step; bus("rr_rd_again", 1, 1, 1, 0);
    step; chk("rr_wait_ack0", {31'd0, ack0}, 0);
    step; chk("rr_ack0", {31'd0, ack0}, 1); chk("rr_rdata0", rdata0, 32'h2222); req0 = 0;
    step; chk("rr_ack0_pulse", {31'd0, ack0}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jp1_pio_arbiter.md
# jp1_pio_arbiter

Sequencing controller and two-port arbiter for the Expansion JP1 parallel-port PIO slave. After reset it configures the PIO (direction register, then interrupt mask). It then shares the PIO's register bus between two requesters using round-robin grant, and services PIO interrupts by reading and clearing the edge-capture register. It sits between accelerator-side clients and the PIO's address/chipselect/write_n/writedata/readdata/irq pins.

## Interface
- DIR_INIT, 32'hFFFFFFFF, value written to PIO register 1 (direction) after reset
- IRQ_MASK_INIT, 32'h00000000, value written to PIO register 2 (interrupt mask) after reset
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req0 / req1  in  1  request; held high until matching ack; fields stable while high
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  2  PIO register index 0..3
- wdata0 / wdata1  in  32  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  32  read result; valid in the ack cycle, held until next read for that port
- address  out  2  to PIO
- chipselect  out  1  to PIO
- write_n  out  1  to PIO, active-low write strobe
- writedata  out  32  to PIO
- readdata  in  32  from PIO; valid one cycle after the read bus cycle
- irq  in  1  from PIO
- evt_valid  out  1  one-cycle pulse: interrupt event captured
- evt_data  out  32  captured edge-capture value; valid with evt_valid, held after

## Operation
- States: INIT_DIR, INIT_MASK, IDLE, WR, RD, RD_WAIT, DONE, IRQ_RD, IRQ_WAIT, IRQ_CLR.
- Bus outputs are decoded from the state and latched fields. Idle bus is chipselect=0, write_n=1, address=0, writedata=0.
- Bus is idle in IDLE, RD_WAIT, DONE and IRQ_WAIT.
- INIT_DIR: write address 1 with DIR_INIT. Go to INIT_MASK.
- INIT_MASK: write address 2 with IRQ_MASK_INIT. Go to IDLE.
- IDLE decision priority:
  - irq=1: go to IRQ_RD.
  - Else, one req high: grant it.
  - Else, both high: grant the port not granted last. The last-grant pointer resets to 1, so port 0 wins the first tie.
  - Granting latches we/addr/wdata and the port id, updates the pointer, then goes to WR (we=1) or RD (we=0).
- WR: chipselect=1, write_n=0, latched address/data. Go to DONE.
- RD: chipselect=1, write_n=1, latched address. Go to RD_WAIT.
- RD_WAIT: capture readdata into the granted port's rdata. Go to DONE.
- DONE: pulse the granted port's ack. Go to IDLE.
- IRQ_RD: read address 3. Go to IRQ_WAIT.
- IRQ_WAIT: latch readdata into evt_data and pulse evt_valid. Go to IRQ_CLR.
- IRQ_CLR: write address 3 with the captured value (clears exactly the captured bits). Go to IDLE.
- Interrupt service is never preempted by requests. A pending request waits, req held, and no request is ever dropped.
- Continuous interrupt edges can starve requesters; this is accepted.

## Timing
- While reset=1: all outputs are 0 except write_n=1. rdata0/1 and evt_data clear to 0. State becomes INIT_DIR and the pointer becomes 1.
- First cycle after reset falls: INIT_DIR bus write. Next cycle: INIT_MASK write. Third cycle: IDLE.
- Write latency: request sampled in IDLE at cycle N. Bus write at N+1, ack at N+2, IDLE at N+3.
- Read latency: bus read at N+1, capture at N+2, ack with rdata at N+3.
- A requester must drop req at the edge where it sees ack. If req is still high in the following IDLE, it is a new request.
- Reset mid-operation (any state):
  - In-flight ack and evt_valid are not issued.
  - The init sequence restarts.
  - Still-held requests are served after init.
- Simultaneous irq and req in IDLE: irq wins. The req is served in the IDLE after IRQ_CLR (irq already low, since the clear takes effect that edge).
- Exactly one chipselect cycle per transaction. Never two consecutive bus cycles for different transactions without an intervening IDLE.

## Test plan
- Reset, then release:
  - Cycle 0: address=1, writedata=FFFFFFFF, chipselect=1, write_n=0.
  - Cycle 1: address=2, writedata=0.
  - Cycle 2: chipselect=0.
  - No acks.
- req0 write, addr0=0, wdata0=1023:
  - Bus cycle with address=0, writedata=0x3FF, write_n=0.
  - ack0 pulses exactly one cycle later; ack1 stays 0.
- req0 (write 0 ← 1123) and req1 (write 0 ← 1120) raised in the same cycle:
  - Bus writes 0x463, then 0x460.
  - ack0 precedes ack1 by 3 cycles.
  - Repeat the tie: port 1 now wins first.
- req1 read of addr 0; PIO model drives readdata=0x0000A5A5 the cycle after the read strobe:
  - ack1 pulses with rdata1=0x0000A5A5; rdata0 unchanged.
- irq=1 while req0 pending; model returns edge-capture 0x4:
  - Read of address 3.
  - evt_valid with evt_data=0x4.
  - Write of address 3 with 0x4.
  - Model lowers irq; then req0 is served and acked.
- reset pulsed during RD_WAIT of a held req0 read:
  - No ack0.
  - Bus idle during reset.
  - Init writes repeat.
  - The read is re-executed and ack0 returns with fresh data.
